csa16_seq_ctrl: RTL and testbench



---
 rtl/csa16_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_csa16_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/csa16_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | csa16_seq_ctrl : three-operand adder, one 4-bit carry-save slice/cycle |
// | csa            : 4-bit carry-save adder (sum and carry vectors)        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module csa (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [3:0] z,
   output logic [3:0] s,
   output logic [3:0] cy
);
   assign s  = x ^ y ^ z;
   assign cy = (x & y) | (x & z) | (y & z);
endmodule

module csa16_seq_ctrl #(
   parameter int NSLICE = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NSLICE-1:0]     a,
   input  logic [4*NSLICE-1:0]     b,
   input  logic [4*NSLICE-1:0]     c,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*NSLICE+1:0]     sum,
   output logic                    busy
);
   localparam int W  = 4 * NSLICE;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] c_idx_last = IW'(NSLICE - 1);
   localparam logic [IW-1:0] c_idx_one  = IW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_c;
   logic [1:0]      r_carry;
   logic [W+1:0]    r_sum;
   logic [IW-1:0]   r_idx;

   logic [W-1:0]    w_a_sh;
   logic [W-1:0]    w_b_sh;
   logic [W-1:0]    w_c_sh;
   logic [3:0]      w_s;
   logic [3:0]      w_cy;
   logic [5:0]      w_t;
   logic            w_last;
   logic            w_accept;

   // Operands are shifted down so the active nibble always sits at bit 0.
   assign w_a_sh = r_a >> {r_idx, 2'b00};
   assign w_b_sh = r_b >> {r_idx, 2'b00};
   assign w_c_sh = r_c >> {r_idx, 2'b00};

   csa u_csa (
      .x  (w_a_sh[3:0]),
      .y  (w_b_sh[3:0]),
      .z  (w_c_sh[3:0]),
      .s  (w_s),
      .cy (w_cy)
   );

   // Carry vector has weight 2; slice total stays within 0..47.
   assign w_t      = {2'b00, w_s} + {1'b0, w_cy, 1'b0} + {4'b0000, r_carry};
   assign w_last   = (r_idx == c_idx_last);
   assign w_accept = (r_state == S_IDLE) && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_carry <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_c     <= c;
         r_carry <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum[{r_idx, 2'b00} +: 4] <= w_t[3:0];
         r_carry                    <= w_t[5:4];
         if (w_last) begin
            r_sum[W+1:W] <= w_t[5:4];
         end else begin
            r_idx <= r_idx + c_idx_one;
         end
      end
   end

   assign sum = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_csa16_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_csa16_seq_ctrl : vector table, directed corners, random traffic     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_csa16_seq_ctrl;
   localparam int NSLICE = 4;
   localparam int W      = 4 * NSLICE;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [W-1:0]  c = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W+1:0]  sum;
   logic          busy;

   int n_cmp  = 0;
   int n_fail = 0;

   csa16_seq_ctrl #(.NSLICE(NSLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W+1:0] exp;
      int           hold;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] x, y, z);
      int unsigned t;
      t = int'(x) + int'(y) + int'(z);
      return t[W+1:0];
   endfunction

   // One full transaction: accept, scrambled inputs during RUN, optional backpressure.
   task automatic do_txn(input logic [W-1:0] va, vb, vc, input logic [W+1:0] exp, input int hold);
      int cyc;
      a = va; b = vb; c = vc;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      cyc = 0;
      while (!in_ready && cyc < 20) begin tick(); cyc++; end
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      tick();
      check("busy_in_run", 64'(busy), 64'd1);
      check("in_ready_in_run", 64'(in_ready), 64'd0);
      check("sum_cleared_on_accept", 64'(sum), 64'd0);
      a = ~va; b = va ^ vb; c = vc + 16'h1357;
      cyc = 0;
      while (!out_valid && cyc < 20) begin tick(); cyc++; end
      in_valid = 1'b0;
      check("latency", 64'(cyc), 64'(NSLICE));
      check("sum_result", 64'(sum), 64'(exp));
      check("sum_model", 64'(sum), 64'(model(va, vb, vc)));
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_sum", 64'(sum), 64'(exp));
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_consume_out_valid", 64'(out_valid), 64'd0);
      check("post_consume_in_ready", 64'(in_ready), 64'd1);
      check("post_consume_busy", 64'(busy), 64'd0);
      check("post_consume_sum_kept", 64'(sum), 64'(exp));
   endtask

   initial begin
      vec_t vecs[5];
      logic [W+1:0] q_exp[$];
      int last_acc, n_acc, n_done, cyc;
      logic acc_now;

      vecs[0] = '{16'h0001, 16'h0002, 16'h0003, 18'h00006, 0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 18'h2FFFD, 0};
      vecs[2] = '{16'h1234, 16'h1111, 16'h0F0F, 18'h03254, 10};
      vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 18'h00000, 0};
      vecs[4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 18'h1FFFE, 2};

      #3;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++)
         do_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].hold);

      // Reset while slice 2 is about to be processed.
      a = 16'h7777; b = 16'h8888; c = 16'h9999;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
      check("midrun_rst_busy", 64'(busy), 64'd0);
      check("midrun_rst_sum", 64'(sum), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rst_held_out_valid", 64'(out_valid), 64'd0);
      end
      rst_n = 1'b1;
      tick();
      do_txn(16'h8000, 16'h8000, 16'h8000, 18'h18000, 1);

      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra, rb, rc;
         ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
         do_txn(ra, rb, rc, model(ra, rb, rc), int'($urandom_range(0, 3)));
      end

      // Back-to-back with both handshakes permanently enabled.
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      last_acc = -1; n_acc = 0; n_done = 0; cyc = 0;
      while (n_done < 8 && cyc < 200) begin
         acc_now = 1'b0;
         if (in_ready && n_acc < 8) begin
            q_exp.push_back(model(a, b, c));
            if (last_acc >= 0) check("b2b_period", 64'(cyc - last_acc), 64'(NSLICE + 2));
            last_acc = cyc;
            n_acc++;
            acc_now = 1'b1;
         end
         if (out_valid) begin
            if (q_exp.size() > 0) check("b2b_sum", 64'(sum), 64'(q_exp.pop_front()));
            else check("b2b_unexpected_out", 64'(out_valid), 64'd0);
            n_done++;
         end
         tick();
         cyc++;
         if (acc_now) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            if (n_acc == 8) in_valid = 1'b0;
         end
      end
      check("b2b_results", 64'(n_done), 64'd8);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
